// File: rtl/rll_key_loader.sv
// rll_key_loader: serial key loader with atomic commit and per-net XOR/XNOR key gates.
// Shadow key is filled CHUNK_W bits per beat, LSB chunk first. It is copied into the
// active key in a single COMMIT cycle. net_out is the registered, key-gated net_in.
// Optional feature macro: RLL_KEY_PARITY_EN (key_par / key_err parity check on commit).
module rll_key_loader #(
   parameter int unsigned      KEY_W     = 16,
   parameter int unsigned      CHUNK_W   = 4,
   parameter logic [KEY_W-1:0] XNOR_MASK = '0,
   parameter logic [KEY_W-1:0] NOT_MASK  = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_clear,
   input  logic               key_valid,
   output logic               key_ready,
   input  logic [CHUNK_W-1:0] key_data,
   output logic               key_loaded,
`ifdef RLL_KEY_PARITY_EN
   input  logic               key_par,
   output logic               key_err,
`endif
   input  logic [KEY_W-1:0]   net_in,
   output logic [KEY_W-1:0]   net_out
);

   localparam int unsigned      BEATS     = KEY_W / CHUNK_W;
   localparam int unsigned      BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
   // Both masks only ever flip the gate output, so they fold into one constant.
   localparam logic [KEY_W-1:0] GATE_MASK = XNOR_MASK ^ NOT_MASK;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [KEY_W-1:0] shadow_q, shadow_d;
   logic [KEY_W-1:0] active_q, active_d;
   logic [KEY_W-1:0] net_q, net_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic             ready_q, ready_d;
   logic             loaded_q, loaded_d;
   logic             beat_fire_c;
`ifdef RLL_KEY_PARITY_EN
   logic             err_q, err_d;
`endif

   // State and datapath registers; reset wipes every key bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         shadow_q <= '0;
         active_q <= '0;
         net_q    <= '0;
         beat_q   <= '0;
         ready_q  <= 1'b0;
         loaded_q <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         net_q    <= net_d;
         beat_q   <= beat_d;
         ready_q  <= ready_d;
         loaded_q <= loaded_d;
`ifdef RLL_KEY_PARITY_EN
         err_q    <= err_d;
`endif
      end
   end

   // Next-state: beat capture, commit, clear priority, key gating.
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      beat_d      = beat_q;
      loaded_d    = loaded_q;
`ifdef RLL_KEY_PARITY_EN
      err_d       = err_q;
`endif
      net_d       = net_in ^ active_q ^ GATE_MASK;
      beat_fire_c = key_valid & ready_q;

      if (key_clear) begin
         // Clear wins over any beat arriving in the same cycle.
         state_d  = ST_IDLE;
         shadow_d = '0;
         active_d = '0;
         beat_d   = '0;
         loaded_d = 1'b0;
`ifdef RLL_KEY_PARITY_EN
         err_d    = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_LOAD: begin
               if (beat_fire_c) begin
                  for (int k = 0; k < int'(BEATS); k++) begin
                     if (beat_q == BW'(k)) shadow_d[k*CHUNK_W +: CHUNK_W] = key_data;
                  end
                  if (beat_q == LAST_BEAT) begin
                     beat_d = '0;
`ifdef RLL_KEY_PARITY_EN
                     if (key_par == ^shadow_d) begin
                        state_d = ST_COMMIT;
                     end else begin
                        state_d  = ST_IDLE;
                        shadow_d = '0;
                        err_d    = 1'b1;
                     end
`else
                     state_d = ST_COMMIT;
`endif
                  end else begin
                     beat_d  = beat_q + BW'(1);
                     state_d = ST_LOAD;
                  end
               end
            end
            ST_COMMIT: begin
               active_d = shadow_q;
               loaded_d = 1'b1;
`ifdef RLL_KEY_PARITY_EN
               err_d    = 1'b0;
`endif
               state_d  = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Loader stalls for exactly the COMMIT cycle.
      ready_d = (state_d != ST_COMMIT);
   end

   assign key_ready  = ready_q;
   assign key_loaded = loaded_q;
   assign net_out    = net_q;
`ifdef RLL_KEY_PARITY_EN
   assign key_err    = err_q;
`endif

endmodule

// File: tb/tb_rll_key_loader.sv
// Bench for rll_key_loader (KEY_W=16, CHUNK_W=4, XNOR_MASK=16'hA5A5, NOT_MASK=0).
module tb_rll_key_loader;

   localparam int unsigned KEY_W   = 16;
   localparam int unsigned CHUNK_W = 4;
   localparam int unsigned BEATS   = KEY_W / CHUNK_W;
   localparam logic [15:0] XM      = 16'hA5A5;
   localparam logic [15:0] NM      = 16'h0000;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        key_clear = 1'b0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic [3:0]  key_data  = 4'h0;
   logic        key_loaded;
   logic [15:0] net_in    = 16'h0;
   logic [15:0] net_out;
`ifdef RLL_KEY_PARITY_EN
   logic        key_par   = 1'b0;
   logic        key_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;
   int consumed;

   always #5 clk = ~clk;

   rll_key_loader #(
      .KEY_W    (KEY_W),
      .CHUNK_W  (CHUNK_W),
      .XNOR_MASK(XM),
      .NOT_MASK (NM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_clear (key_clear),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_data  (key_data),
      .key_loaded(key_loaded),
`ifdef RLL_KEY_PARITY_EN
      .key_par   (key_par),
      .key_err   (key_err),
`endif
      .net_in    (net_in),
      .net_out   (net_out)
   );

   // Behavioural model: accepted chunks queue up; a full set becomes a pending key.
   logic [15:0] m_active = 16'h0;
   logic [15:0] m_pend   = 16'h0;
   logic [15:0] m_net    = 16'h0;
   logic [15:0] m_key;
   bit          m_loaded = 1'b0;
   bit          m_commit = 1'b0;
   bit          m_ready  = 1'b0;
   bit          m_err    = 1'b0;
   logic [3:0]  chunks[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 16'h0; m_pend = 16'h0; m_net = 16'h0;
         m_loaded = 1'b0; m_commit = 1'b0; m_ready = 1'b0; m_err = 1'b0;
         chunks.delete();
      end else begin
         m_net = net_in ^ m_active ^ XM ^ NM;
         if (key_clear) begin
            m_active = 16'h0; m_loaded = 1'b0; m_commit = 1'b0; m_err = 1'b0;
            chunks.delete();
         end else if (m_commit) begin
            m_active = m_pend; m_loaded = 1'b1; m_err = 1'b0; m_commit = 1'b0;
         end else if (key_valid && m_ready) begin
            chunks.push_back(key_data);
            if (chunks.size() == BEATS) begin
               m_key = 16'h0;
               foreach (chunks[j]) m_key = m_key | (16'(chunks[j]) << (4 * j));
`ifdef RLL_KEY_PARITY_EN
               if (key_par == ^m_key) begin m_pend = m_key; m_commit = 1'b1; end
               else m_err = 1'b1;
`else
               m_pend = m_key; m_commit = 1'b1;
`endif
               chunks.delete();
            end
         end
         m_ready = !m_commit;
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Every-cycle compare of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_ready",   16'(key_ready),  16'(m_ready));
         chk("cyc_loaded",  16'(key_loaded), 16'(m_loaded));
         chk("cyc_net_out", net_out,         m_net);
`ifdef RLL_KEY_PARITY_EN
         chk("cyc_key_err", 16'(key_err),    16'(m_err));
`endif
      end
   end

   task automatic send_key(input logic [15:0] k);
      for (int j = 0; j < 4; j++) begin
         key_valid = 1'b1;
         key_data  = k[j*4 +: 4];
         @(negedge clk);
      end
      key_valid = 1'b0;
   endtask

   initial begin
      // Test 1: reset with a valid beat and all-ones nets presented
      key_valid = 1'b1;
      net_in    = 16'hFFFF;
      chk_en    = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_net_out", net_out,         16'h0000);
      chk("rst_ready",   16'(key_ready),  16'h0);
      chk("rst_loaded",  16'(key_loaded), 16'h0);
      key_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 16'(key_ready), 16'h1);

      // Test 2: all-zero key before first commit
      net_in = 16'h1234;
      @(negedge clk);
      chk("pre_commit_net",    net_out,         16'hB791);
      chk("pre_commit_loaded", 16'(key_loaded), 16'h0);
      chk("model_net_pin",     m_net,           16'hB791);

      // Test 3: load correct key A5A5
      send_key(16'hA5A5);
      chk("commit_ready_low",  16'(key_ready),  16'h0);
      chk("commit_not_loaded", 16'(key_loaded), 16'h0);
      @(negedge clk);
      chk("commit_loaded",     16'(key_loaded), 16'h1);
      chk("commit_ready_back", 16'(key_ready),  16'h1);
      chk("model_active_pin",  m_active,        16'hA5A5);
      @(negedge clk);
      chk("correct_key_net",   net_out,         16'h1234);

      // Test 4: load key 0000 with key_valid held through COMMIT
      consumed = 0;
      for (int i = 0; i < 5; i++) begin
         key_valid = 1'b1;
         key_data  = 4'h0;
         if (key_ready) consumed++;
         @(negedge clk);
      end
      key_valid = 1'b0;
      @(negedge clk);
      chk("beats_consumed",  16'(consumed),    16'd4);
      chk("zero_key_net",    net_out,         16'hB791);
      chk("zero_key_loaded", 16'(key_loaded), 16'h1);

      // Test 5a: clear during a partial load
      send_key(16'hA5A5);
      repeat (2) @(negedge clk);
      key_valid = 1'b1; key_data = 4'h3;
      @(negedge clk);
      key_data = 4'hC;
      @(negedge clk);
      chk("partial_keeps_active", net_out, 16'h1234);
      key_data = 4'h7; key_clear = 1'b1;
      @(negedge clk);
      key_clear = 1'b0; key_valid = 1'b0;
      chk("clear_loaded", 16'(key_loaded), 16'h0);
      chk("clear_ready",  16'(key_ready),  16'h1);
      @(negedge clk);
      chk("clear_net",    net_out,         16'hB791);
      send_key(16'h5A3C);
      @(negedge clk);
      chk("reload_after_clear", 16'(key_loaded), 16'h1);
      @(negedge clk);
      chk("reload_net",         net_out,         16'hEDAD);

      // Test 5b: reset pulse after beat 1
      key_valid = 1'b1; key_data = 4'h1;
      @(negedge clk);
      key_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midload_rst_net",    net_out,         16'h0000);
      chk("midload_rst_ready",  16'(key_ready),  16'h0);
      chk("midload_rst_loaded", 16'(key_loaded), 16'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      send_key(16'hA5A5);
      @(negedge clk);
      chk("fresh_load_after_rst", 16'(key_loaded), 16'h1);

`ifdef RLL_KEY_PARITY_EN
      // Test 6: bad then good parity
      key_par = 1'b1;
      send_key(16'hA5A5);
      @(negedge clk);
      chk("par_bad_err",    16'(key_err),    16'h1);
      chk("par_bad_loaded", 16'(key_loaded), 16'h1);
      key_par = 1'b0;
      send_key(16'hA5A5);
      @(negedge clk);
      chk("par_good_err",    16'(key_err),    16'h0);
      chk("par_good_loaded", 16'(key_loaded), 16'h1);
`endif

      // Randomized traffic with occasional clear and reset
      for (int c = 0; c < 600; c++) begin
         key_valid = ($urandom_range(9) < 7);
         key_data  = 4'($urandom);
         net_in    = 16'($urandom);
         key_clear = ($urandom_range(39) == 0);
`ifdef RLL_KEY_PARITY_EN
         key_par   = 1'($urandom);
`endif
         if ($urandom_range(199) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      key_valid = 1'b0;
      key_clear = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
